// File: rtl/pcs_tx_arb.sv
// pcs_tx_arb: frame-granular round-robin arbiter for the PCS TX AXIS port, with in-order response routing
module pcs_tx_arb #(
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       tx_user_clk_i,
    input  logic                       tx_user_rst_n_i,
    input  logic [2*DATA_W-1:0]        req_data_i,
    input  logic [2*(DATA_W/16)-1:0]   req_vldb_i,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0]                 req_last_i,
    input  logic [1:0]                 req_user_i,
    output logic [1:0]                 req_status_o,
    output logic [1:0]                 req_rsp_valid_o,
    output logic [DATA_W-1:0]          tx_data_o,
    output logic [DATA_W/16-1:0]       tx_vldb_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic                       tx_last_o,
    output logic                       tx_user_o,
    input  logic                       tx_status_i,
    input  logic                       tx_rsp_valid_i,
    output logic [1:0]                 grant_o,
    output logic                       rsp_err_o
);
    localparam int VW = DATA_W / 16;
    localparam int AW = $clog2(RSP_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]           state;
    logic                 owner;
    logic                 last_winner;
    logic                 win;
    logic                 xfer;
    logic                 push;
    logic                 pop;
    logic                 fire;
    logic                 head;
    logic [RSP_DEPTH-1:0] fifo;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          cnt;

    // Arbitration, owner mux and response routing
    always_comb begin
        xfer            = state == XFER;
        win             = last_winner ? ~req_valid_i[0] : req_valid_i[1];
        push            = !xfer && |req_valid_i && !cnt[AW];
        pop             = tx_rsp_valid_i && cnt != '0;
        head            = fifo[rd_ptr];
        tx_data_o       = xfer ? (owner ? req_data_i[2*DATA_W-1:DATA_W] : req_data_i[DATA_W-1:0]) : '0;
        tx_vldb_o       = xfer ? (owner ? req_vldb_i[2*VW-1:VW] : req_vldb_i[VW-1:0]) : '0;
        tx_valid_o      = xfer && req_valid_i[owner];
        tx_last_o       = xfer && req_last_i[owner];
        tx_user_o       = xfer && req_user_i[owner];
        req_ready_o     = xfer ? (owner ? {tx_ready_i, 1'b0} : {1'b0, tx_ready_i}) : 2'b00;
        grant_o         = xfer ? (owner ? 2'b10 : 2'b01) : 2'b00;
        fire            = tx_valid_o && tx_ready_i && tx_last_o;
        req_rsp_valid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
        req_status_o    = req_rsp_valid_o & {2{tx_status_i}};
    end

    // Frame-level FSM: grant in IDLE, release on the last accepted beat
    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
        end else if (push) begin
            state <= XFER;
            owner <= win;
        end else if (fire) begin
            state       <= IDLE;
            last_winner <= owner;
        end
    end

    // Owner FIFO: one entry per granted frame, popped by each PCS response
    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            fifo   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) fifo[wr_ptr] <= win;
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, push};
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
            cnt    <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Sticky flag for a response with no frame outstanding
    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) rsp_err_o <= 1'b0;
        else if (tx_rsp_valid_i && cnt == '0) rsp_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_pcs_tx_arb.sv
// tb_pcs_tx_arb: directed self-checking bench for pcs_tx_arb
module tb_pcs_tx_arb;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*DW-1:0] req_data;
    logic [3:0]    req_vldb;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_last;
    logic [1:0]    req_user;
    logic [1:0]    req_status;
    logic [1:0]    req_rsp_valid;
    logic [DW-1:0] tx_data;
    logic [1:0]    tx_vldb;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;
    logic          tx_user;
    logic          tx_status;
    logic          tx_rsp_valid;
    logic [1:0]    grant;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    pcs_tx_arb #(.DATA_W(DW), .RSP_DEPTH(4)) dut (
        .tx_user_clk_i   (clk),
        .tx_user_rst_n_i (rst_n),
        .req_data_i      (req_data),
        .req_vldb_i      (req_vldb),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_last_i      (req_last),
        .req_user_i      (req_user),
        .req_status_o    (req_status),
        .req_rsp_valid_o (req_rsp_valid),
        .tx_data_o       (tx_data),
        .tx_vldb_o       (tx_vldb),
        .tx_valid_o      (tx_valid),
        .tx_ready_i      (tx_ready),
        .tx_last_o       (tx_last),
        .tx_user_o       (tx_user),
        .tx_status_i     (tx_status),
        .tx_rsp_valid_i  (tx_rsp_valid),
        .grant_o         (grant),
        .rsp_err_o       (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_data     = {32'hB1B1_0001, 32'hA0A0_0000};
        req_vldb     = 4'b1101;
        req_valid    = 2'b00;
        req_last     = 2'b00;
        req_user     = 2'b01;
        tx_ready     = 1'b1;
        tx_status    = 1'b0;
        tx_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send1(input int id);
        req_valid = 2'b01 << id;
        req_last  = 2'b11;
        @(negedge clk);
        #1;
        chk("t4_grant", grant, 64'(2'b01 << id));
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    logic [1:0] exp_g [17] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                               2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    int bc [2];
    logic [1:0] hs;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_data", tx_data, 0);
        do_reset();

        // 1: req0 three-beat frame
        req_valid = 2'b01;
        req_data[31:0] = 32'h0000_0011;
        #1;
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_valid", tx_valid, 0);
        @(negedge clk);
        #1;
        chk("t1_grant", grant, 2'b01);
        chk("t1_b1", tx_data, 32'h0000_0011);
        chk("t1_ready", req_ready, 2'b01);
        chk("t1_user", tx_user, 1);
        chk("t1_vldb", tx_vldb, 2'b01);
        @(negedge clk);
        req_data[31:0] = 32'h0000_0022;
        #1;
        chk("t1_b2", tx_data, 32'h0000_0022);
        chk("t1_nolast", tx_last, 0);
        @(negedge clk);
        req_data[31:0] = 32'h0000_0033;
        req_last = 2'b01;
        #1;
        chk("t1_b3", tx_data, 32'h0000_0033);
        chk("t1_last", tx_last, 1);
        @(negedge clk);
        req_valid = 2'b00;
        req_last  = 2'b00;
        #1;
        chk("t1_release", grant, 0);

        // 2+3: both stream 2-beat frames until the owner FIFO fills, then one response
        do_reset();
        bc[0] = 0;
        bc[1] = 0;
        for (int i = 0; i < 17; i++) begin
            req_valid    = 2'b11;
            req_last     = {bc[1] == 1, bc[0] == 1};
            tx_rsp_valid = (i == 14);
            #1;
            chk($sformatf("t23_grant_c%0d", i), grant, exp_g[i]);
            if (i == 1) chk("t2_data0", tx_data, 32'hA0A0_0000);
            if (i == 4) chk("t2_data1", tx_data, 32'hB1B1_0001);
            if (i == 4) chk("t2_vldb1", tx_vldb, 2'b11);
            if (i == 14) chk("t3_rsp", req_rsp_valid, 2'b01);
            hs = req_ready;
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (hs[k]) bc[k] = (bc[k] == 1) ? 0 : bc[k] + 1;
        end

        // 4: frames req1, req0, req1 then responses 1,0,1
        do_reset();
        send1(1);
        send1(0);
        send1(1);
        tx_rsp_valid = 1'b1;
        tx_status    = 1'b1;
        #1;
        chk("t4_rv0", req_rsp_valid, 2'b10);
        chk("t4_st0", req_status, 2'b10);
        @(negedge clk);
        tx_status = 1'b0;
        #1;
        chk("t4_rv1", req_rsp_valid, 2'b01);
        chk("t4_st1", req_status, 2'b00);
        @(negedge clk);
        tx_status = 1'b1;
        #1;
        chk("t4_rv2", req_rsp_valid, 2'b10);
        chk("t4_st2", req_status, 2'b10);
        @(negedge clk);
        tx_rsp_valid = 1'b0;
        #1;
        chk("t4_noerr", rsp_err, 0);

        // 5: orphan response
        tx_rsp_valid = 1'b1;
        tx_status    = 1'b1;
        #1;
        chk("t5_rv", req_rsp_valid, 2'b00);
        chk("t5_st", req_status, 2'b00);
        @(negedge clk);
        tx_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_err_held", rsp_err, 1);
            @(negedge clk);
        end
        do_reset();
        #1;
        chk("t5_err_clr", rsp_err, 0);

        // 6: reset on beat 2 of a 4-beat frame
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_b2_grant", grant, 2'b01);
        chk("t6_b2_valid", tx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", tx_valid, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ready", req_ready, 0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tx_rsp_valid = 1'b1;
        #1;
        chk("t6_empty_rv", req_rsp_valid, 2'b00);
        @(negedge clk);
        tx_rsp_valid = 1'b0;
        req_valid    = 2'b11;
        #1;
        chk("t6_empty_err", rsp_err, 1);
        @(negedge clk);
        #1;
        chk("t6_first_grant", grant, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
